// File: rtl/id_ex_stage_pkg.sv
// Shared RV32I decode constants and small opcode classification helpers
// used by the decode stage and its immediate generator.
package id_ex_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // Immediate format carried by each opcode; anything else has no immediate.
  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_type_of = IMM_I;
      OPC_STORE:                      imm_type_of = IMM_S;
      OPC_BRANCH:                     imm_type_of = IMM_B;
      OPC_LUI, OPC_AUIPC:             imm_type_of = IMM_U;
      OPC_JAL:                        imm_type_of = IMM_J;
      default:                        imm_type_of = IMM_NONE;
    endcase
  endfunction

  // rs1 is read by everything except the U-type and JAL formats.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: uses_rs1 = 1'b0;
      default:                     uses_rs1 = 1'b1;
    endcase
  endfunction

  // rs2 is read only by register-register ALU ops, stores and branches.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      OPC_OP, OPC_STORE, OPC_BRANCH: uses_rs2 = 1'b1;
      default:                       uses_rs2 = 1'b0;
    endcase
  endfunction

  // Opcodes whose result is written back to rd.
  function automatic logic writes_rd(input logic [6:0] opcode);
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
      default:                      writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// Combinational immediate decoder: instruction word -> sign-extended immediate.
module id_ex_stage_imm_gen
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32_s;

  // Reassemble the scattered immediate bits for the format implied by the opcode.
  always_comb begin
    imm32_s = 32'd0;
    case (imm_type_of(instr[6:0]))
      IMM_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32_s = {instr[31:12], 12'd0};
      IMM_J:   imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32_s = 32'd0;
    endcase
  end

  assign imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/id_ex_stage.sv
// Decode / operand-fetch stage and ID/EX pipeline register. Resolves operands
// through the EX/MEM/WB bypass network, detects load-use hazards and holds a
// saturating count of stall cycles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [XLEN-1:0]  id_pc,
  input  logic             flush,
  output logic [4:0]       rf_op1_addr,
  output logic [4:0]       rf_op2_addr,
  input  logic [XLEN-1:0]  rf_op1_data,
  input  logic [XLEN-1:0]  rf_op2_data,
  input  logic             ex_fwd_en,
  input  logic [4:0]       ex_fwd_rd,
  input  logic [XLEN-1:0]  ex_fwd_value,
  input  logic             mem_fwd_en,
  input  logic [4:0]       mem_fwd_rd,
  input  logic [XLEN-1:0]  mem_fwd_value,
  input  logic             wb_fwd_en,
  input  logic [4:0]       wb_fwd_rd,
  input  logic [XLEN-1:0]  wb_fwd_value,
  output logic             stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_op1,
  output logic [XLEN-1:0]  ex_op2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rd,
  output logic [6:0]       ex_opcode,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic             ex_is_load,
  output logic             ex_reg_write,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [6:0]      opcode_s;
  logic [4:0]      rs1_s;
  logic [4:0]      rs2_s;
  logic [4:0]      rd_s;
  logic [XLEN-1:0] op1_s;
  logic [XLEN-1:0] op2_s;
  logic [XLEN-1:0] imm_s;
  logic            stall_s;
  logic            live_s;

  assign opcode_s    = id_instr[6:0];
  assign rd_s        = id_instr[11:7];
  assign rs1_s       = id_instr[19:15];
  assign rs2_s       = id_instr[24:20];
  assign rf_op1_addr = rs1_s;
  assign rf_op2_addr = rs2_s;

  id_ex_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (id_instr),
    .imm   (imm_s)
  );

  // rs1 bypass: youngest in-flight producer wins; WB covers the same-cycle file write.
  always_comb begin
    op1_s = rf_op1_data;
    if (rs1_s == 5'd0) begin
      op1_s = '0;
    end else if (ex_fwd_en && (ex_fwd_rd == rs1_s)) begin
      op1_s = ex_fwd_value;
    end else if (mem_fwd_en && (mem_fwd_rd == rs1_s)) begin
      op1_s = mem_fwd_value;
    end else if (wb_fwd_en && (wb_fwd_rd == rs1_s)) begin
      op1_s = wb_fwd_value;
    end else begin
      op1_s = rf_op1_data;
    end
  end

  // rs2 bypass, same priority as rs1.
  always_comb begin
    op2_s = rf_op2_data;
    if (rs2_s == 5'd0) begin
      op2_s = '0;
    end else if (ex_fwd_en && (ex_fwd_rd == rs2_s)) begin
      op2_s = ex_fwd_value;
    end else if (mem_fwd_en && (mem_fwd_rd == rs2_s)) begin
      op2_s = mem_fwd_value;
    end else if (wb_fwd_en && (wb_fwd_rd == rs2_s)) begin
      op2_s = wb_fwd_value;
    end else begin
      op2_s = rf_op2_data;
    end
  end

  // Load-use hazard: load data is not available from EX, so hold ID one cycle
  // until the load reaches MEM. Flush and reset both suppress the stall.
  always_comb begin
    stall_s = 1'b0;
    if (reset || flush || !id_valid) begin
      stall_s = 1'b0;
    end else if (ex_valid && ex_is_load && (ex_rd != 5'd0)) begin
      stall_s = (uses_rs1(opcode_s) && (rs1_s == ex_rd)) ||
                (uses_rs2(opcode_s) && (rs2_s == ex_rd));
    end else begin
      stall_s = 1'b0;
    end
  end

  assign stall  = stall_s;
  assign live_s = id_valid && !flush && !stall_s;

  // ID/EX register: loads every cycle; control bits become a bubble when not live.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_op1       <= '0;
      ex_op2       <= '0;
      ex_imm       <= '0;
      ex_rd        <= 5'd0;
      ex_opcode    <= 7'd0;
      ex_funct3    <= 3'd0;
      ex_funct7b5  <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_reg_write <= 1'b0;
    end else begin
      ex_valid     <= live_s;
      ex_pc        <= id_pc;
      ex_op1       <= op1_s;
      ex_op2       <= op2_s;
      ex_imm       <= imm_s;
      ex_rd        <= rd_s;
      ex_opcode    <= opcode_s;
      ex_funct3    <= id_instr[14:12];
      ex_funct7b5  <= id_instr[30];
      ex_is_load   <= live_s && (opcode_s == OPC_LOAD);
      ex_reg_write <= live_s && writes_rd(opcode_s) && (rd_s != 5'd0);
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_s && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// instruction streams, all checked against a behavioural model of the stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        flush;
  logic [4:0]  rf_op1_addr, rf_op2_addr;
  logic [31:0] rf_op1_data, rf_op2_data;
  logic        ex_fwd_en, mem_fwd_en, wb_fwd_en;
  logic [4:0]  ex_fwd_rd, mem_fwd_rd, wb_fwd_rd;
  logic [31:0] ex_fwd_value, mem_fwd_value, wb_fwd_value;
  logic        stall, ex_valid, ex_funct7b5, ex_is_load, ex_reg_write;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm, stall_cnt;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  int n_chk  = 0;
  int n_fail = 0;

  // model state: what the EX register is expected to hold
  logic        m_valid, m_is_load;
  logic [4:0]  m_rd;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .flush(flush), .rf_op1_addr(rf_op1_addr), .rf_op2_addr(rf_op2_addr),
    .rf_op1_data(rf_op1_data), .rf_op2_data(rf_op2_data),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_value(ex_fwd_value),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_value(mem_fwd_value),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_value(wb_fwd_value),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit op_in(input logic [6:0] op, input int kind);
    // kind 0: no rs1, 1: uses rs2, 2: writes rd
    case (kind)
      0: return op == 7'h37 || op == 7'h17 || op == 7'h6F;
      1: return op == 7'h33 || op == 7'h23 || op == 7'h63;
      default: return op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h37 ||
                      op == 7'h17 || op == 7'h6F || op == 7'h67;
    endcase
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] w);
    int v;
    logic [6:0] op;
    op = w[6:0];
    if (op == 7'h13 || op == 7'h03 || op == 7'h67)
      v = $signed(w) >>> 20;
    else if (op == 7'h23)
      v = (($signed(w) >>> 25) * 32) + int'(w[11:7]);
    else if (op == 7'h63)
      v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    else if (op == 7'h37 || op == 7'h17)
      v = int'(w & 32'hFFFFF000);
    else if (op == 7'h6F)
      v = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    else
      v = 0;
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_operand(input logic [4:0] a, input logic [31:0] rf);
    logic        en  [3];
    logic [4:0]  rd  [3];
    logic [31:0] val [3];
    en = '{ex_fwd_en, mem_fwd_en, wb_fwd_en};
    rd = '{ex_fwd_rd, mem_fwd_rd, wb_fwd_rd};
    val = '{ex_fwd_value, mem_fwd_value, wb_fwd_value};
    if (a == 5'd0) return 32'd0;
    for (int k = 0; k < 3; k++)
      if (en[k] && rd[k] == a) return val[k];
    return rf;
  endfunction

  // One clock: check combinational outputs, clock, check the EX register.
  task automatic tick();
    logic [31:0] w, e_op1, e_op2, e_imm;
    logic [6:0]  op;
    logic        u1, u2, e_stall, live;
    #1;
    w  = id_instr;
    op = w[6:0];
    u1 = !op_in(op, 0);
    u2 = op_in(op, 1);
    e_stall = !reset && id_valid && !flush && m_valid && m_is_load && m_rd != 5'd0 &&
              ((u1 && w[19:15] == m_rd) || (u2 && w[24:20] == m_rd));
    live  = !reset && id_valid && !flush && !e_stall;
    e_op1 = model_operand(w[19:15], rf_op1_data);
    e_op2 = model_operand(w[24:20], rf_op2_data);
    e_imm = model_imm(w);
    chk("rf_op1_addr", 32'(rf_op1_addr), 32'(w[19:15]));
    chk("rf_op2_addr", 32'(rf_op2_addr), 32'(w[24:20]));
    chk("stall", 32'(stall), 32'(e_stall));
    @(posedge clk);
    #1;
    if (reset) begin
      m_valid = 1'b0; m_is_load = 1'b0; m_rd = 5'd0; m_cnt = 32'd0;
      chk("rst_ex_pc", ex_pc, 32'd0);
      chk("rst_ex_op1", ex_op1, 32'd0);
      chk("rst_ex_imm", ex_imm, 32'd0);
      chk("rst_ex_opcode", 32'(ex_opcode), 32'd0);
      chk("rst_ex_reg_write", 32'(ex_reg_write), 32'd0);
    end else begin
      m_valid   = live;
      m_is_load = live && op == 7'h03;
      m_rd      = w[11:7];
      if (e_stall && m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 32'd1;
      chk("ex_reg_write", 32'(ex_reg_write), 32'(live && op_in(op, 2) && w[11:7] != 5'd0));
      if (live) begin
        chk("ex_pc", ex_pc, id_pc);
        chk("ex_op1", ex_op1, e_op1);
        chk("ex_op2", ex_op2, e_op2);
        chk("ex_imm", ex_imm, e_imm);
        chk("ex_rd", 32'(ex_rd), 32'(w[11:7]));
        chk("ex_ctrl", {17'd0, ex_opcode, ex_funct3, ex_funct7b5, 4'd0},
            {17'd0, op, w[14:12], w[30], 4'd0});
      end
    end
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("ex_is_load", 32'(ex_is_load), 32'(m_is_load));
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic clear_fwd();
    ex_fwd_en = 0; mem_fwd_en = 0; wb_fwd_en = 0;
    ex_fwd_rd = 0; mem_fwd_rd = 0; wb_fwd_rd = 0;
    ex_fwd_value = 0; mem_fwd_value = 0; wb_fwd_value = 0;
  endtask

  initial begin
    m_valid = 0; m_is_load = 0; m_rd = 0; m_cnt = 0;
    reset = 1; id_valid = 0; id_instr = 32'h00000013; id_pc = 32'h100; flush = 0;
    rf_op1_data = 32'h11; rf_op2_data = 32'h22;
    clear_fwd();

    // reset
    tick(); tick();
    chk("reset_ex_valid", 32'(ex_valid), 32'd0);
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    reset = 0;

    // ADDI x1,x0,5 then ADD x2,x1,x1 with x1 forwarded from EX
    id_valid = 1; id_instr = 32'h00500093; id_pc = 32'h100;
    tick();
    chk("addi_imm", ex_imm, 32'd5);
    id_instr = 32'h00108133; id_pc = 32'h104;
    ex_fwd_en = 1; ex_fwd_rd = 5'd1; ex_fwd_value = 32'd5;
    tick();
    chk("add_fwd_op1", ex_op1, 32'd5);
    chk("add_fwd_op2", ex_op2, 32'd5);
    clear_fwd();

    // LW x3 then dependent ADD x4,x3,x0: one stall, then MEM bypass
    id_instr = 32'h00002183; id_pc = 32'h108;
    tick();
    id_instr = 32'h00018233; id_pc = 32'h10C;
    #1 chk("loaduse_stall", 32'(stall), 32'd1);
    tick();
    chk("loaduse_bubble", 32'(ex_valid), 32'd0);
    mem_fwd_en = 1; mem_fwd_rd = 5'd3; mem_fwd_value = 32'h0000DEAD;
    #1 chk("loaduse_released", 32'(stall), 32'd0);
    tick();
    chk("loaduse_op1", ex_op1, 32'h0000DEAD);
    chk("loaduse_cnt", stall_cnt, 32'd1);
    clear_fwd();

    // WB bypass beats stale file data; x0 source reads zero
    id_instr = 32'h000283B3; id_pc = 32'h110;
    rf_op1_data = 32'd3; rf_op2_data = 32'h55;
    wb_fwd_en = 1; wb_fwd_rd = 5'd5; wb_fwd_value = 32'd7;
    tick();
    chk("wb_fwd_op1", ex_op1, 32'd7);
    chk("x0_op2", ex_op2, 32'd0);
    clear_fwd();

    // all three stages target x6: EX has priority
    id_instr = 32'h00030433; id_pc = 32'h114;
    ex_fwd_en = 1; ex_fwd_rd = 5'd6; ex_fwd_value = 32'd1;
    mem_fwd_en = 1; mem_fwd_rd = 5'd6; mem_fwd_value = 32'd2;
    wb_fwd_en = 1; wb_fwd_rd = 5'd6; wb_fwd_value = 32'd3;
    tick();
    chk("prio_op1", ex_op1, 32'd1);
    clear_fwd();

    // flush with a load-use hazard pending
    id_instr = 32'h00002183; id_pc = 32'h118;
    tick();
    id_instr = 32'h00018233; id_pc = 32'h11C; flush = 1;
    #1 chk("flush_no_stall", 32'(stall), 32'd0);
    tick();
    chk("flush_bubble", 32'(ex_valid), 32'd0);
    flush = 0;

    // BEQ x0,x0,-8
    id_instr = 32'hFE000CE3; id_pc = 32'h120;
    tick();
    chk("beq_imm", ex_imm, 32'hFFFFFFF8);

    // LW x8 then LUI x9,0x12345 whose rs1 field aliases x8: no stall
    id_instr = 32'h00002403; id_pc = 32'h124;
    tick();
    id_instr = 32'h123454B7; id_pc = 32'h128;
    #1 chk("lui_no_stall", 32'(stall), 32'd0);
    tick();
    chk("lui_imm", ex_imm, 32'h12345000);
    chk("lui_valid", 32'(ex_valid), 32'd1);

    // reset asserted during a load-use stall
    id_instr = 32'h00002183; id_pc = 32'h12C;
    tick();
    id_instr = 32'h00018233; reset = 1;
    #1 chk("rst_mid_stall", 32'(stall), 32'd0);
    tick();
    chk("rst_mid_valid", 32'(ex_valid), 32'd0);
    chk("rst_mid_cnt", stall_cnt, 32'd0);
    reset = 0;

    // random instruction stream
    for (int n = 0; n < 400; n++) begin
      logic [6:0] ops [10];
      logic [31:0] w;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73};
      w = $urandom();
      w[6:0]   = ops[$urandom_range(0, 9)];
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      id_instr = w;
      id_pc = $urandom();
      id_valid = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 99) == 0);
      rf_op1_data = $urandom(); rf_op2_data = $urandom();
      ex_fwd_en = 1'($urandom()); ex_fwd_rd = 5'($urandom_range(0, 7)); ex_fwd_value = $urandom();
      mem_fwd_en = 1'($urandom()); mem_fwd_rd = 5'($urandom_range(0, 7)); mem_fwd_value = $urandom();
      wb_fwd_en = 1'($urandom()); wb_fwd_rd = 5'($urandom_range(0, 7)); wb_fwd_value = $urandom();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
